sort_batch_streamer: RTL and testbench

//  Stream front/back end for bitonic_sorting_top. Packs a valid/ready word stream into one
//  2**LOG_INPUT_NUM-wide batch and pads any short batch. Launches the sorter with a
//  one-cycle x_valid, then captures y on y_valid. Replays the sorted real elements as a

---
 rtl/sort_batch_streamer_if.sv | 34 +++
 rtl/sort_batch_streamer.sv | 92 +++++++++
 tb/tb_sort_batch_streamer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sort_batch_streamer_if.sv
// sort_batch_streamer_if: word-stream, sorter and status signals of sort_batch_streamer
//   s_valid/s_ready/s_data/s_last  packed-batch input stream
//   x_valid/x, y_valid/y           sorter launch and result, slot i at [i*DATAWIDTH +: DATAWIDTH]
//   m_valid/m_ready/m_data/m_last  sorted output stream
//   busy, err_timeout              status
//   slave = streamer view, master = surrounding system view
interface sort_batch_streamer_if #(
  parameter int LOG_INPUT_NUM = 3,
  parameter int DATAWIDTH     = 32
);
  localparam int N = 1 << LOG_INPUT_NUM;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATAWIDTH-1:0]   s_data;
  logic                   s_last;
  logic                   x_valid;
  logic [N*DATAWIDTH-1:0] x;
  logic [N*DATAWIDTH-1:0] y;
  logic                   y_valid;
  logic                   m_valid;
  logic                   m_ready;
  logic [DATAWIDTH-1:0]   m_data;
  logic                   m_last;
  logic                   busy;
  logic                   err_timeout;
  modport slave (
    input  s_valid, s_data, s_last, y, y_valid, m_ready,
    output s_ready, x_valid, x, m_valid, m_data, m_last, busy, err_timeout
  );
  modport master (
    output s_valid, s_data, s_last, y, y_valid, m_ready,
    input  s_ready, x_valid, x, m_valid, m_data, m_last, busy, err_timeout
  );
endinterface

// File: rtl/sort_batch_streamer.sv
// sort_batch_streamer: packs a word stream into a padded batch, launches the sorter, replays sorted words
//   clk     clock, posedge
//   resetn  asynchronous active-low reset
//   bus     sort_batch_streamer_if.slave (input stream, sorter x/y, output stream, busy, err_timeout)
//   SORT_TIMEOUT_EN: when defined, WAIT gives up after TIMEOUT_CYCLES and raises sticky err_timeout
module sort_batch_streamer #(
  parameter int                   LOG_INPUT_NUM  = 3,
  parameter int                   DATAWIDTH      = 32,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE      = {DATAWIDTH{1'b1}},
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 resetn,
  sort_batch_streamer_if.slave bus
);
  localparam int N = 1 << LOG_INPUT_NUM;
  localparam logic [LOG_INPUT_NUM:0] N_CNT = N;
  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;
  state_t                   r_state, w_state_nxt;
  logic [LOG_INPUT_NUM:0]   r_cnt;
  logic [LOG_INPUT_NUM-1:0] r_idx;
  logic [N*DATAWIDTH-1:0]   r_x;
  logic [N*DATAWIDTH-1:0]   r_ybuf;
  logic [LOG_INPUT_NUM:0]   w_cnt_inc;
  logic                     w_fire_in;
  logic                     w_last;
  logic                     w_done_out;
  logic                     w_tmo_hit;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_fire_in  = (r_state == FILL) & bus.s_valid;
  assign w_last     = {1'b0, r_idx} == r_cnt - 1'b1;
  assign w_done_out = (r_state == DRAIN) & bus.m_ready & w_last;
  assign bus.x      = r_x;
`ifdef SORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;
  assign w_tmo_hit       = (r_state == WAIT) & ~bus.y_valid & (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign bus.err_timeout = r_err;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
      r_err <= r_err | w_tmo_hit;
    end
`else
  assign w_tmo_hit       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif
  always_comb begin
    w_state_nxt  = r_state;
    bus.s_ready  = r_state == FILL;
    bus.x_valid  = r_state == LAUNCH;
    bus.m_valid  = r_state == DRAIN;
    bus.m_data   = (r_state == DRAIN) ? r_ybuf[r_idx*DATAWIDTH +: DATAWIDTH] : '0;
    bus.m_last   = (r_state == DRAIN) & w_last;
    bus.busy     = !((r_state == FILL) && (r_cnt == '0));
    case (r_state)
      FILL:    w_state_nxt = (w_fire_in && (bus.s_last || w_cnt_inc == N_CNT)) ? LAUNCH : FILL;
      LAUNCH:  w_state_nxt = WAIT;
      WAIT:    w_state_nxt = bus.y_valid ? DRAIN : (w_tmo_hit ? FILL : WAIT);
      DRAIN:   w_state_nxt = w_done_out ? FILL : DRAIN;
      default: w_state_nxt = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_x     <= {N{PAD_VALUE}};
      r_ybuf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire_in) begin
        r_x[r_cnt[LOG_INPUT_NUM-1:0]*DATAWIDTH +: DATAWIDTH] <= bus.s_data;
        r_cnt <= w_cnt_inc;
      end
      if (r_state == WAIT && bus.y_valid) begin
        r_ybuf <= bus.y;
        r_idx  <= '0;
      end
      if (r_state == DRAIN && bus.m_ready) r_idx <= r_idx + 1'b1;
      // slots go back to pad so the next short batch sorts its pad to the tail
      if (w_done_out || w_tmo_hit) begin
        r_cnt <= '0;
        r_x   <= {N{PAD_VALUE}};
      end
    end
endmodule

// File: tb/tb_sort_batch_streamer.sv
// tb_sort_batch_streamer: directed checks of batching, padding, drain backpressure, reset and timeout
module tb_sort_batch_streamer;
  localparam int L = 3;
  localparam int N = 8;
  localparam int DW = 32;
  localparam logic [DW-1:0] P = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sort_batch_streamer_if #(.LOG_INPUT_NUM(L), .DATAWIDTH(DW)) bus ();
  sort_batch_streamer #(.LOG_INPUT_NUM(L), .DATAWIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [DW-1:0] w [8], input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = w[i];
      bus.s_last  = last && (i == n - 1);
      chk("s_ready_fill", bus.s_ready, 1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask
  task automatic launch_chk(input logic [N*DW-1:0] xe);
    chk("x_valid_rise", bus.x_valid, 1);
    chk("x_slots", bus.x, xe);
    @(negedge clk);
    chk("x_valid_fall", bus.x_valid, 0);
    chk("s_ready_wait", bus.s_ready, 0);
  endtask
  task automatic sort_resp(input int lat);
    logic [DW-1:0] a [N];
    logic [DW-1:0] t;
    for (int i = 0; i < N; i++) a[i] = bus.x[i*DW +: DW];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    repeat (lat) @(negedge clk);
    for (int i = 0; i < N; i++) bus.y[i*DW +: DW] = a[i];
    bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    chk("y_to_m_valid", bus.m_valid, 1);
  endtask
  task automatic collect(input logic [DW-1:0] e [8], input int n, input bit toggle);
    int k = 0;
    int budget = 200;
    bit ph = 1'b1;
    bit stalled = 1'b0;
    logic [DW-1:0] prev = '0;
    while (k < n && budget > 0) begin
      bus.m_ready = toggle ? ph : 1'b1;
      ph = !ph;
      if (bus.m_valid) begin
        if (stalled) chk("stall_stable", bus.m_data, prev);
        chk("m_data", bus.m_data, e[k]);
        chk("m_last", bus.m_last, k == n - 1);
        chk("s_ready_drain", bus.s_ready, 0);
        stalled = !bus.m_ready;
        prev = bus.m_data;
        if (bus.m_ready) k++;
      end
      @(negedge clk);
      budget--;
    end
    bus.m_ready = 1'b0;
    chk("drain_count", k, n);
    chk("m_valid_after", bus.m_valid, 0);
    chk("s_ready_after", bus.s_ready, 1);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    bus.y       = '0;
    bus.y_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_x_valid", bus.x_valid, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_x", bus.x, {N{P}});
    resetn = 1'b1;
    @(negedge clk);
    send('{8, 3, 7, 1, 6, 2, 5, 4}, 8, 1'b1);
    launch_chk({32'd4, 32'd5, 32'd2, 32'd6, 32'd1, 32'd7, 32'd3, 32'd8});
    sort_resp(3);
    collect('{1, 2, 3, 4, 5, 6, 7, 8}, 8, 1'b0);
    send('{9, 2, 5, 0, 0, 0, 0, 0}, 3, 1'b1);
    launch_chk({P, P, P, P, P, 32'd5, 32'd2, 32'd9});
    sort_resp(2);
    collect('{2, 5, 9, 0, 0, 0, 0, 0}, 3, 1'b0);
    send('{20, 10, 70, 30, 80, 50, 60, 40}, 8, 1'b0);
    launch_chk({32'd40, 32'd60, 32'd50, 32'd80, 32'd30, 32'd70, 32'd10, 32'd20});
    sort_resp(1);
    collect('{10, 20, 30, 40, 50, 60, 70, 80}, 8, 1'b1);
    send('{7, 3, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    launch_chk({P, P, P, P, P, P, 32'd3, 32'd7});
    repeat (2) @(negedge clk);
    chk("busy_wait", bus.busy, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_s_ready", bus.s_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_x", bus.x, {N{P}});
    @(negedge clk);
    resetn = 1'b1;
    bus.y = {N{32'd1}};
    bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    chk("stale_y_m_valid", bus.m_valid, 0);
    @(negedge clk);
    chk("stale_y_m_valid2", bus.m_valid, 0);
    chk("stale_y_s_ready", bus.s_ready, 1);
    send('{4, 1, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    launch_chk({P, P, P, P, P, P, 32'd1, 32'd4});
    sort_resp(0);
    collect('{1, 4, 0, 0, 0, 0, 0, 0}, 2, 1'b0);
    send('{2, 1, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    launch_chk({P, P, P, P, P, P, 32'd1, 32'd2});
    chk("b2b_busy1", bus.busy, 1);
    sort_resp(1);
    collect('{1, 2, 0, 0, 0, 0, 0, 0}, 2, 1'b0);
    chk("b2b_busy_gap", bus.busy, 0);
    send('{6, 5, 4, 0, 0, 0, 0, 0}, 3, 1'b1);
    chk("b2b_busy2", bus.busy, 1);
    launch_chk({P, P, P, P, P, 32'd4, 32'd5, 32'd6});
    sort_resp(1);
    collect('{4, 5, 6, 0, 0, 0, 0, 0}, 3, 1'b0);
    send('{3, 2, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    launch_chk({P, P, P, P, P, P, 32'd2, 32'd3});
`ifdef SORT_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("tmo_err_c16", bus.err_timeout, 0);
    chk("tmo_s_ready_c16", bus.s_ready, 0);
    @(negedge clk);
    chk("tmo_err", bus.err_timeout, 1);
    chk("tmo_s_ready", bus.s_ready, 1);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_x_pad", bus.x, {N{P}});
    repeat (4) @(negedge clk);
    chk("tmo_sticky", bus.err_timeout, 1);
`else
    repeat (20) @(negedge clk);
    chk("notmo_err", bus.err_timeout, 0);
    chk("notmo_s_ready", bus.s_ready, 0);
    chk("notmo_busy", bus.busy, 1);
    sort_resp(0);
    collect('{2, 3, 0, 0, 0, 0, 0, 0}, 2, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
